// File: rtl/jtopl_ser_pkg.sv
// Shared constants, FSM state type and mantissa-range helper for the JTOPL serial transmitter.
// Optional linear (unencoded) frame format: define JTOPL_SER_LINEAR_EN.
package jtopl_ser_pkg;

    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned MANT_W    = 10;
    localparam int unsigned EXP_W     = 3;
    localparam int unsigned SLOT_W    = $clog2(FRAME_LEN);
    localparam int unsigned MANT_LSB  = 3;
    localparam int unsigned EXP_LSB   = 13;
    localparam int unsigned SH_SLOT   = 15;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // True when x is a sign extension of its low MANT_W bits.
    function automatic logic fits_mant(input logic [15:0] x);
        logic [16-MANT_W:0] top;
        top = x[15:MANT_W-1];
        return (top == '0) || (top == '1);
    endfunction

endpackage

// File: rtl/jtopl_ser_enc.sv
// Combinational encoder: 16-bit signed sample to the 16-slot frame word {exp, mant, 3'b000}.
// With JTOPL_SER_LINEAR_EN defined the sample passes through unencoded.
module jtopl_ser_enc
    import jtopl_ser_pkg::*;
(
    input  logic [15:0]          snd,
    output logic [FRAME_LEN-1:0] frame_c
);

`ifdef JTOPL_SER_LINEAR_EN
    assign frame_c = snd;
`else
    logic [15:0]       shifted;
    logic [EXP_W-1:0]  exp_c;
    logic [MANT_W-1:0] mant_c;

    // Scan from the largest shift down so the smallest fitting exponent wins.
    always_comb begin
        exp_c   = EXP_W'(7);
        shifted = '0;
        for (int k = 6; k >= 0; k--) begin
            shifted = $signed(snd) >>> k;
            if (fits_mant(shifted)) begin
                exp_c = EXP_W'(k + 1);
            end
        end
        mant_c  = MANT_W'($signed(snd) >>> (exp_c - EXP_W'(1)));
        frame_c = '0;
        frame_c[MANT_LSB +: MANT_W] = mant_c;
        frame_c[EXP_LSB +: EXP_W]   = exp_c;
    end
`endif

endmodule

// File: rtl/jtopl_ser_tx.sv
// Serial sample transmitter: one-deep pending buffer feeding an LSB-first 16-slot frame shifter.
// Frame format selected in jtopl_ser_enc by JTOPL_SER_LINEAR_EN (undefined: floating point).
module jtopl_ser_tx #(
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] snd,
    input  logic        snd_valid,
    output logic        sd,
    output logic        sh,
    output logic        busy,
    output logic        overrun
);
    import jtopl_ser_pkg::*;

    state_t                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [FRAME_LEN-1:0]  sr_q, sr_d;
    logic [15:0]           pend_data_q, pend_data_d;
    logic                  pend_full_q, pend_full_d;
    logic                  sd_q, sd_d;
    logic                  sh_q, sh_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  xfer_c;
    logic                  last_slot_c;
    logic [FRAME_LEN-1:0]  frame_c;

    jtopl_ser_enc u_enc (
        .snd     (pend_data_q),
        .frame_c (frame_c)
    );

    assign last_slot_c = (slot_q == SLOT_W'(SH_SLOT));

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sr_d        = sr_q;
        sd_d        = sd_q;
        sh_d        = sh_q;
        xfer_c      = 1'b0;
        pend_data_d = pend_data_q;
        pend_full_d = pend_full_q;

        case (state_q)
            IDLE: begin
                if (cen) begin
                    sd_d = 1'b0;
                    sh_d = 1'b0;
                    if (pend_full_q) begin
                        xfer_c  = 1'b1;
                        sr_d    = frame_c;
                        slot_d  = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cen) begin
                    sd_d   = sr_q[0];
                    sh_d   = last_slot_c;
                    sr_d   = sr_q >> 1;
                    slot_d = slot_q + SLOT_W'(1);
                    // Wrap: reload back-to-back or drop to idle.
                    if (last_slot_c) begin
                        slot_d = '0;
                        if (pend_full_q) begin
                            xfer_c = 1'b1;
                            sr_d   = frame_c;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new strobe wins over the transfer, so pending stays full.
        if (snd_valid) begin
            pend_data_d = snd;
            pend_full_d = 1'b1;
        end else if (xfer_c) begin
            pend_full_d = 1'b0;
        end

        overrun_d = snd_valid && pend_full_q && !xfer_c;
        busy_d    = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            sr_q        <= '0;
            pend_data_q <= '0;
            pend_full_q <= 1'b0;
            sd_q        <= 1'b0;
            sh_q        <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sr_q        <= sr_d;
            pend_data_q <= pend_data_d;
            pend_full_q <= pend_full_d;
            sd_q        <= sd_d;
            sh_q        <= sh_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sd      = sd_q;
    assign sh      = sh_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: doc/jtopl_ser_tx.md
# jtopl_ser_tx

Serial sample transmitter for the JTOPL output path. It takes the 16-bit signed linear sample produced by the operator accumulator and encodes it into the YM3014-style 13-bit floating-point word: 10-bit signed mantissa plus 3-bit exponent. It then shifts the word out LSB-first in 16-slot frames, paced by a bit-clock enable, for an external or emulated serial DAC. A one-deep pending buffer decouples the accumulator's sample strobe from frame timing.

## Interface
Parameters:
- FRAME_LEN, 16: bit slots per frame. Fixed by format; only 16 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cen  in  1  bit-slot clock enable; one slot advances per cycle with cen=1
- snd  in  16  signed linear sample from the accumulator
- snd_valid  in  1  one-cycle strobe: capture snd into the pending buffer
- sd  out  1  serial data, registered
- sh  out  1  latch strobe, high during slot 15 of each frame
- busy  out  1  high while a frame is being shifted
- overrun  out  1  one-clk pulse when a pending sample is overwritten

## Operation
- Pending buffer: register pend_data[15:0] with flag pend_full.
  - snd_valid=1: pend_data<=snd and pend_full<=1, on any cycle regardless of cen.
  - snd_valid with pend_full=1 and no transfer that cycle: overwrite pend_data and pulse overrun.
- FSM states:
  - IDLE: sd=0, sh=0, busy=0. On cen with pend_full=1: load shift register from encoder(pend_data), clear pend_full, slot<=0, go to SHIFT.
  - SHIFT: on each cen, drive sd from the current slot bit and set sh=(slot==15). Increment slot, which wraps from 15 to 0.
    - At the wrap with pend_full=1: reload from pending, giving back-to-back frames with no gap.
    - At the wrap with pend_full=0: go to IDLE.
- Frame slots, LSB first:
  - slots 0-2: 0
  - slots 3-12: mantissa[0..9]
  - slots 13-15: exponent[0..2]
- Encoding:
  - e (1..7) is the smallest value such that snd>>>(e-1) fits a signed 10-bit range (-512..511).
  - Mantissa = snd>>>(e-1), arithmetic shift with floor truncation.
  - e=7 always fits, so no saturation is needed.
- Simultaneous snd_valid and transfer out of pending: the new sample lands in pending, pend_full stays 1, and no overrun is raised.
- Reset (asynchronous, any time including mid-frame): state IDLE, slot 0, pend_full 0, shift register 0. All outputs are 0.

## Timing
- Reset value of every output: sd=0, sh=0, busy=0, overrun=0.
- snd_valid at cycle t with FSM idle:
  - Pending is valid from t+1.
  - The transfer happens on the first cen at or after t+1.
  - Slot 0 appears on sd at the next cen after the transfer.
- sd and sh change only on cycles with cen=1 and hold between enables.
- busy rises with the transfer cycle and falls on the cen that completes slot 15 with no pending sample.
- overrun is high for exactly one clk and is independent of cen.
- A frame lasts 16 cen pulses. The sustained throughput requirement is at most one snd_valid per 16 cen.

## Configuration
- JTOPL_SER_LINEAR_EN:
  - Defined: the encoder is bypassed and the 16 slots carry snd[0..15] raw, LSB first. sh stays in slot 15.
  - Undefined (default): floating-point format as above.

## Structure
- Package jtopl_ser_pkg holds:
  - FRAME_LEN, MANT_W=10, EXP_W=3
  - slot constants MANT_LSB=3, EXP_LSB=13, SH_SLOT=15
  - FSM state enum {IDLE, SHIFT}
- Sub-module jtopl_ser_enc: combinational encoder, snd[15:0] to {exp[2:0], mant[9:0]}. Its linear bypass is selected by JTOPL_SER_LINEAR_EN.
- Pending buffer, FSM, slot counter and shift register live in jtopl_ser_tx.

## Test plan
- snd=0x0100, single strobe: frame is 000, mantissa 0x100, exp 001. sh is high only in slot 15, and busy drops after slot 15.
- snd=0x7FFF, then snd=0x8000 within one frame: two frames back-to-back with no idle slot. The first carries mant 0x1FF, exp 7; the second mant 0x200, exp 7. No overrun.
- snd=0xFDFF (-513): mant 0x2FF (-257), exp 2.
- Three strobes (0x0001, 0x0002, 0x0003) inside one frame: one overrun pulse. The frames carry 0x0001 and then 0x0003, and 0x0002 is never transmitted.
- snd_valid on the same clk as the wrap-time reload: the new sample goes to pending, no overrun, and it is sent in the following frame.
- rst asserted at slot 7: all outputs read 0 immediately, and the pending sample is lost. After release, idle until the next snd_valid.
- With JTOPL_SER_LINEAR_EN defined, snd=0xA5C3: slots 0-15 carry 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
